// File: rtl/par_to_ser.sv
// Parallel-to-serial converter: MSB-first shifter with a one-word holding buffer
// so that consecutive words stream out with no idle gap between them.
module par_to_ser #(
    parameter int   DATA_WIDTH = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  fastClk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wordIn,
    input  logic                  wordValid,
    output logic                  wordReady,
    output logic                  dataOut,
    output logic                  busy,
    output logic                  wordDone
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  accept;

    // Ready depends only on stored state and reset, never on wordValid.
    assign wordReady = ~buf_full_q & reset;
    assign accept    = wordValid & wordReady;

    assign busy     = (state_q == SHIFT);
    assign wordDone = (state_q == SHIFT) && (cnt_q == '0);
    assign dataOut  = (state_q == SHIFT) ? shift_q[DATA_WIDTH-1] : IDLE_LEVEL;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = wordIn;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - 1'b1;
                    if (accept) begin
                        buf_d      = wordIn;
                        buf_full_d = 1'b1;
                    end
                end else if (buf_full_q) begin
                    // Last bit out: refill from the buffer so the next word follows seamlessly.
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    cnt_d      = CNT_LAST;
                end else if (accept) begin
                    shift_d = wordIn;
                    cnt_d   = CNT_LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge fastClk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_par_to_ser.sv
// Self-checking bench for par_to_ser: a queue of accepted words plus a bit position
// predicts every output each cycle; directed streams and random traffic with resets.
module tb_par_to_ser;

    localparam int   W    = 4;
    localparam logic IDLE = 1'b0;

    logic         fastClk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] wordIn = '0;
    logic         wordValid = 1'b0;
    logic         wordReady;
    logic         dataOut;
    logic         busy;
    logic         wordDone;

    par_to_ser #(
        .DATA_WIDTH(W),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .fastClk  (fastClk),
        .reset    (reset),
        .wordIn   (wordIn),
        .wordValid(wordValid),
        .wordReady(wordReady),
        .dataOut  (dataOut),
        .busy     (busy),
        .wordDone (wordDone)
    );

    always #5 fastClk = ~fastClk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference: words accepted but not yet fully emitted, front word is on the line.
    logic [W-1:0] mq[$];
    int           bit_pos = 0;

    logic [31:0]  cap = '0;
    int           ncap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return reset && (mq.size() < 2);
    endfunction

    task automatic model_edge(input logic acc, input logic [W-1:0] w);
        if (mq.size() > 0) begin
            bit_pos++;
            if (bit_pos == W) begin
                void'(mq.pop_front());
                bit_pos = 0;
            end
        end
        if (acc) mq.push_back(w);
    endtask

    task automatic check_outputs();
        logic exp_busy;
        logic exp_data;
        logic exp_done;
        exp_busy = (mq.size() > 0);
        exp_data = IDLE;
        exp_done = 1'b0;
        if (exp_busy) begin
            exp_data = mq[0][W-1-bit_pos];
            exp_done = (bit_pos == W - 1);
        end
        check("busy", 32'(busy), 32'(exp_busy));
        check("dataOut", 32'(dataOut), 32'(exp_data));
        check("wordDone", 32'(wordDone), 32'(exp_done));
        check("wordReady", 32'(wordReady), 32'(model_ready()));
        if (busy) begin
            cap = {cap[30:0], dataOut};
            ncap++;
        end
        if (wordDone && exp_done) check("word", 32'(cap[W-1:0]), 32'(mq[0]));
    endtask

    // Called between a falling and the next rising edge; returns on the falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] w);
        logic acc;
        wordValid = v;
        wordIn    = w;
        acc       = v && model_ready();
        @(posedge fastClk);
        model_edge(acc, w);
        @(negedge fastClk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * W + 4 && mq.size() > 0; i++) cycle(1'b0, W'($urandom));
        cycle(1'b0, W'($urandom));
    endtask

    // Holds wordValid high on each word until the model says it was taken.
    task automatic send_held(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2);
        logic [W-1:0] words[3];
        int idx;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        idx = 0;
        for (int i = 0; i < 40 && idx < 3; i++) begin
            if (model_ready()) begin
                cycle(1'b1, words[idx]);
                idx++;
            end else begin
                cycle(1'b1, words[idx]);
            end
        end
        check("held_all_sent", 32'(idx), 32'd3);
    endtask

    task automatic pulse_reset(input int hold);
        #2;
        reset = 1'b0;
        mq.delete();
        bit_pos = 0;
        #1;
        check("rst_dataOut", 32'(dataOut), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(wordReady), 32'd0);
        check("rst_done", 32'(wordDone), 32'd0);
        @(negedge fastClk);
        for (int i = 0; i < hold; i++) cycle(1'($urandom_range(0, 1)), W'($urandom));
        reset = 1'b1;
        #1;
        check("ready_after_release", 32'(wordReady), 32'd1);
    endtask

    task automatic clear_cap();
        cap  = '0;
        ncap = 0;
    endtask

    initial begin
        repeat (2) @(negedge fastClk);
        check_outputs();
        reset = 1'b1;
        #1;
        check("ready_first_cycle", 32'(wordReady), 32'd1);

        // Single word 1011.
        clear_cap();
        cycle(1'b1, 4'b1011);
        idle_cycles(5);
        check("single_stream", cap, 32'hB);
        check("single_bits", 32'(ncap), 32'd4);

        // Back-to-back A then 5 through the buffer.
        clear_cap();
        cycle(1'b1, 4'hA);
        cycle(1'b1, 4'h5);
        drain();
        check("b2b_stream", cap, 32'hA5);
        check("b2b_bits", 32'(ncap), 32'd8);

        // Direct load exactly at the last-bit edge of 9.
        clear_cap();
        cycle(1'b1, 4'h9);
        idle_cycles(3);
        cycle(1'b1, 4'h6);
        drain();
        check("lastbit_stream", cap, 32'h96);
        check("lastbit_bits", 32'(ncap), 32'd8);

        // Backpressure with wordValid held.
        clear_cap();
        send_held(4'h1, 4'h2, 4'h3);
        drain();
        check("held_stream", cap, 32'h123);
        check("held_bits", 32'(ncap), 32'd12);

        // Reset mid-word with a word buffered: nothing stale afterwards.
        cycle(1'b1, 4'hA);
        cycle(1'b1, 4'h5);
        cycle(1'b0, 4'h0);
        pulse_reset(2);
        clear_cap();
        idle_cycles(6);
        check("no_stale_bits", 32'(ncap), 32'd0);

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset(int'($urandom_range(0, 3)));
            else cycle(1'($urandom_range(0, 9) < 6), W'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
